// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage shared types and constants.
// Opcodes, funct3 codes, MMIO offsets and the MEM->WB bundle.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] MMIO_CTRL = 8'h00;
  localparam logic [7:0] MMIO_RX   = 8'h04;
  localparam logic [7:0] MMIO_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYC  = 8'h10;
  localparam logic [7:0] MMIO_INST = 8'h14;
  localparam logic [7:0] MMIO_CRST = 8'h18;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DMEM,
    SRC_BIOS,
    SRC_MMIO
  } rd_src_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] alu;
    logic [1:0]      boff;
    rd_src_e         src;
    logic [XLEN-1:0] mmio_rdata;
    logic            misaligned;
  } mem_wb_t;

  localparam mem_wb_t WB_RST = '{
    valid:      1'b0,
    inst:       INST_NOP,
    pc4:        '0,
    alu:        '0,
    boff:       2'b00,
    src:        SRC_NONE,
    mmio_rdata: '0,
    misaligned: 1'b0
  };

  function automatic logic has_rd(input logic [6:0] op);
    return (op == OP_LOAD) | (op == OP_IMM)
         | (op == OP_REG)  | (op == OP_LUI)
         | (op == OP_AUIPC)| (op == OP_JAL)
         | (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage memory and UART bus.
// master = the stage, slave = memories and UART.
interface mem_wb_stage_if;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic [31:0] dmem_dout;
  logic [31:0] bios_dout;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready;
  logic [7:0]  uart_rx_data_out;
  logic        uart_rx_data_out_valid;
  logic        uart_rx_data_out_ready;

  modport master (
    output mem_addr, mem_wdata,
    output dmem_we, imem_we,
    output uart_tx_data_in,
    output uart_tx_data_in_valid,
    output uart_rx_data_out_ready,
    input  dmem_dout, bios_dout,
    input  uart_tx_data_in_ready,
    input  uart_rx_data_out,
    input  uart_rx_data_out_valid
  );

  modport slave (
    input  mem_addr, mem_wdata,
    input  dmem_we, imem_we,
    input  uart_tx_data_in,
    input  uart_tx_data_in_valid,
    input  uart_rx_data_out_ready,
    output dmem_dout, bios_dout,
    output uart_tx_data_in_ready,
    output uart_rx_data_out,
    output uart_rx_data_out_valid
  );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// Load alignment: shift raw word to the byte offset,
// then sign- or zero-extend by funct3.
module mem_wb_stage_load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      boff,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;

  assign sh = raw >> {boff, 3'b000};

  // extend the selected byte/half to a full word
  always_comb begin
    data = sh;
    unique case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   data = {24'b0, sh[7:0]};
      F3_HU:   data = {16'b0, sh[15:0]};
      F3_W:    data = sh;
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM: address decode, store lanes, MMIO, counters.
// WB: load align/extend and writeback select.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DWIDTH    = XLEN,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_mem,
  input  logic [DWIDTH-1:0] inst_mem,
  input  logic [DWIDTH-1:0] pc_mem,
  input  logic [DWIDTH-1:0] alu_mem,
  input  logic [DWIDTH-1:0] store_data_mem,
  mem_wb_stage_if.master    bus,
  output logic [DWIDTH-1:0] inst_wb,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DWIDTH-1:0] wb_data,
  output logic              misaligned
);

  localparam logic [3:0] MMIO_RGN = MMIO_BASE[31:28];

  logic [6:0] op;
  logic [1:0] sz;
  logic [1:0] boff;
  logic [3:0] rgn;
  logic [7:0] off;

  assign op   = inst_mem[6:0];
  assign sz   = inst_mem[13:12];
  assign boff = alu_mem[1:0];
  assign rgn  = alu_mem[31:28];
  assign off  = alu_mem[7:0];

  logic unused_ok;
  assign unused_ok = ^alu_mem[27:16];

  logic go, is_ld, is_st;
  logic mis_a, ld_ok, st_ok;
  logic in_dmem, in_imem;
  logic in_bios, in_mmio;

  assign go      = valid_mem & rst_n;
  assign is_ld   = go & (op == OP_LOAD);
  assign is_st   = go & (op == OP_STORE);
  assign in_dmem = (rgn == 4'b0001)
                 | (rgn == 4'b0011);
  assign in_imem = (rgn[3:1] == 3'b001);
  assign in_bios = (rgn == 4'b0100);
  assign in_mmio = (rgn == MMIO_RGN);

  // alignment rule by access size
  always_comb begin
    mis_a = 1'b0;
    unique case (sz)
      2'b01:   mis_a = boff[0];
      2'b10:   mis_a = |boff;
      default: mis_a = 1'b0;
    endcase
  end

  assign misaligned = (is_ld | is_st) & mis_a;
  assign ld_ok      = is_ld & ~mis_a;
  assign st_ok      = is_st & ~mis_a;

  logic [3:0] lane;

  // byte lanes touched by the store
  always_comb begin
    lane = 4'b0000;
    unique case (sz)
      2'b00:   lane = 4'b0001 << boff;
      2'b01:   lane = 4'b0011 << boff;
      2'b10:   lane = 4'b1111;
      default: lane = 4'b0000;
    endcase
  end

  assign bus.mem_addr  = alu_mem[15:2];
  assign bus.mem_wdata =
    store_data_mem << {boff, 3'b000};
  assign bus.dmem_we =
    (st_ok & in_dmem) ? lane : 4'b0000;
  assign bus.imem_we =
    (st_ok & in_imem & pc_mem[30])
      ? lane : 4'b0000;

  logic mmio_st, mmio_ld, cnt_clr;

  assign mmio_st = st_ok & in_mmio;
  assign mmio_ld = ld_ok & in_mmio;
  assign cnt_clr = mmio_st & (off == MMIO_CRST);

  assign bus.uart_tx_data_in =
    store_data_mem[7:0];
  assign bus.uart_tx_data_in_valid =
    mmio_st & (off == MMIO_TX);
  assign bus.uart_rx_data_out_ready =
    mmio_ld & (off == MMIO_RX);

  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;
  mem_wb_t              wb_q;

  // counters; a software clear wins over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (cnt_clr) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + CNT_WIDTH'(1);
      instret_q <= instret_q
                 + CNT_WIDTH'(wb_q.valid);
    end
  end

  logic [XLEN-1:0] mmio_rd;

  // MMIO read mux, sampled into WB
  always_comb begin
    mmio_rd = '0;
    unique case (off)
      MMIO_CTRL: mmio_rd = {30'b0,
        bus.uart_rx_data_out_valid,
        bus.uart_tx_data_in_ready};
      MMIO_RX:   mmio_rd = {24'b0,
        bus.uart_rx_data_out};
      MMIO_CYC:  mmio_rd = XLEN'(cycle_q);
      MMIO_INST: mmio_rd = XLEN'(instret_q);
      default:   mmio_rd = '0;
    endcase
  end

  rd_src_e src;

  // which read port feeds the WB load
  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      in_mmio: src = SRC_MMIO;
      in_bios: src = SRC_BIOS;
      in_dmem: src = SRC_DMEM;
      default: src = SRC_NONE;
    endcase
  end

  mem_wb_t wb_d;

  assign wb_d = '{
    valid:      valid_mem,
    inst:       inst_mem,
    pc4:        pc_mem + 32'd4,
    alu:        alu_mem,
    boff:       boff,
    src:        src,
    mmio_rdata: mmio_rd,
    misaligned: misaligned
  };

  // MEM->WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_q <= WB_RST;
    else        wb_q <= wb_d;
  end

  logic [6:0]      op_wb;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] ld_data;

  assign op_wb = wb_q.inst[6:0];

  // pick the read word that matches the load region
  always_comb begin
    raw = '0;
    unique case (wb_q.src)
      SRC_DMEM: raw = bus.dmem_dout;
      SRC_BIOS: raw = bus.bios_dout;
      SRC_MMIO: raw = wb_q.mmio_rdata;
      default:  raw = '0;
    endcase
  end

  mem_wb_stage_load_extend u_ext (
    .funct3 (wb_q.inst[14:12]),
    .boff   (wb_q.boff),
    .raw    (raw),
    .data   (ld_data)
  );

  assign inst_wb = wb_q.inst;
  assign wb_rd   = wb_q.inst[11:7];

  // writeback data select
  always_comb begin
    wb_data = wb_q.alu;
    unique case (1'b1)
      op_wb == OP_LOAD:
        wb_data = ld_data;
      (op_wb == OP_JAL) | (op_wb == OP_JALR):
        wb_data = wb_q.pc4;
      default:
        wb_data = wb_q.alu;
    endcase
  end

  assign wb_we = wb_q.valid & has_rd(op_wb)
               & (|wb_rd) & ~wb_q.misaligned;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage.
// Expected WB results queued at issue, checked one cycle later.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_mem = 1'b0;
  logic [31:0] inst_mem = 32'h13;
  logic [31:0] pc_mem = 32'h0;
  logic [31:0] alu_mem = 32'h0;
  logic [31:0] store_data_mem = 32'h0;
  logic [31:0] inst_wb;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;

  int n_chk = 0;
  int n_err = 0;

  mem_wb_stage_if bus();

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_mem      (valid_mem),
    .inst_mem       (inst_mem),
    .pc_mem         (pc_mem),
    .alu_mem        (alu_mem),
    .store_data_mem (store_data_mem),
    .bus            (bus),
    .inst_wb        (inst_wb),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misaligned     (misaligned)
  );

  logic [31:0] dmem [16] = '{default: 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.dmem_we[i])
        dmem[bus.mem_addr[3:0]][8*i +: 8]
          <= bus.mem_wdata[8*i +: 8];
    bus.dmem_dout <= dmem[bus.mem_addr[3:0]];
    bus.bios_dout <= 32'hB105_0000
                   | {18'h0, bus.mem_addr};
  end

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] ld(
    input logic [2:0] f3, input logic [4:0] rd);
    return {12'h0, 5'h0, f3, rd, 7'h03};
  endfunction

  function automatic logic [31:0] st(
    input logic [2:0] f3);
    return {7'h0, 5'h0, 5'h0, f3, 5'h0, 7'h23};
  endfunction

  function automatic logic [31:0] addi(
    input logic [4:0] rd);
    return {12'h0, 5'h0, 3'b000, rd, 7'h13};
  endfunction

  task automatic chk(input string tag,
    input logic [31:0] got,
    input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
        tag, got, exp);
    end
  endtask

  task automatic issue(input string tag,
    input logic v, input logic [31:0] inst,
    input logic [31:0] pc, input logic [31:0] a,
    input logic [31:0] sd, input logic ewe,
    input logic [31:0] edata);
    exp_t e;
    valid_mem      = v;
    inst_mem       = inst;
    pc_mem         = pc;
    alu_mem        = a;
    store_data_mem = sd;
    e.tag  = tag;
    e.we   = ewe;
    e.rd   = inst[11:7];
    e.data = edata;
    sb.push_back(e);
    #1;
  endtask

  task automatic bub();
    issue("bub", 1'b0, NOP, 32'h0, 32'h0,
      32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_we"}, {31'h0, wb_we},
        {31'h0, e.we});
      if (e.we) begin
        chk({e.tag, "_rd"}, {27'h0, wb_rd},
          {27'h0, e.rd});
        chk({e.tag, "_data"}, wb_data, e.data);
      end
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] PC  = 32'h0000_0100;
  localparam logic [31:0] PCB = 32'h4000_0100;

  initial begin
    bus.uart_tx_data_in_ready  = 1'b1;
    bus.uart_rx_data_out       = 8'h00;
    bus.uart_rx_data_out_valid = 1'b0;
    repeat (2) @(negedge clk);

    valid_mem = 1'b1;
    inst_mem  = st(3'b010);
    alu_mem   = 32'h1000_0000;
    #1;
    chk("rst_dmem_we", {28'h0, bus.dmem_we}, 32'h0);
    chk("rst_inst_wb", inst_wb, NOP);
    chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
    valid_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      issue("ret", 1'b1, addi(5'd3), PC,
        32'(i + 16), 32'h0, 1'b1, 32'(i + 16));
      tick();
    end
    repeat (5) begin bub(); tick(); end
    issue("instret", 1'b1, ld(3'b010, 5'd6), PC,
      32'h8000_0014, 32'h0, 1'b1, 32'd4);
    tick();
    issue("cycle", 1'b1, ld(3'b010, 5'd6), PC,
      32'h8000_0010, 32'h0, 1'b1, 32'd10);
    tick();

    issue("cnt_clr", 1'b1, st(3'b010), PC,
      32'h8000_0018, 32'h0, 1'b0, 32'h0);
    tick();
    issue("cyc_clr", 1'b1, ld(3'b010, 5'd7), PC,
      32'h8000_0010, 32'h0, 1'b1, 32'd0);
    tick();
    issue("ret_clr", 1'b1, ld(3'b010, 5'd8), PC,
      32'h8000_0014, 32'h0, 1'b1, 32'd1);
    tick();

    issue("sb", 1'b1, st(3'b000), PC,
      32'h1000_0003, 32'h0000_00A5, 1'b0, 32'h0);
    chk("sb_we", {28'h0, bus.dmem_we}, 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'hA500_0000);
    chk("sb_mis", {31'h0, misaligned}, 32'h0);
    tick();
    issue("lb", 1'b1, ld(3'b000, 5'd9), PC,
      32'h1000_0003, 32'h0, 1'b1, 32'hFFFF_FFA5);
    tick();
    issue("lbu", 1'b1, ld(3'b100, 5'd10), PC,
      32'h1000_0003, 32'h0, 1'b1, 32'h0000_00A5);
    tick();

    issue("sh_lo", 1'b1, st(3'b001), PC,
      32'h1000_0004, 32'h0000_BEEF, 1'b0, 32'h0);
    chk("sh_lo_we", {28'h0, bus.dmem_we}, 32'h3);
    chk("sh_lo_addr", {18'h0, bus.mem_addr}, 32'h1);
    tick();
    issue("lh", 1'b1, ld(3'b001, 5'd11), PC,
      32'h1000_0004, 32'h0, 1'b1, 32'hFFFF_BEEF);
    tick();
    issue("lhu", 1'b1, ld(3'b101, 5'd12), PC,
      32'h1000_0004, 32'h0, 1'b1, 32'h0000_BEEF);
    tick();
    issue("sh_hi", 1'b1, st(3'b001), PC,
      32'h1000_0006, 32'h0000_1234, 1'b0, 32'h0);
    chk("sh_hi_we", {28'h0, bus.dmem_we}, 32'hC);
    chk("sh_hi_wdata", bus.mem_wdata, 32'h1234_0000);
    tick();
    issue("lh_hi", 1'b1, ld(3'b001, 5'd13), PC,
      32'h1000_0006, 32'h0, 1'b1, 32'h0000_1234);
    tick();
    issue("lw", 1'b1, ld(3'b010, 5'd14), PC,
      32'h1000_0004, 32'h0, 1'b1, 32'h1234_BEEF);
    tick();

    issue("sw_both", 1'b1, st(3'b010), PCB,
      32'h3000_0008, 32'hCAFE_F00D, 1'b0, 32'h0);
    chk("both_dwe", {28'h0, bus.dmem_we}, 32'hF);
    chk("both_iwe", {28'h0, bus.imem_we}, 32'hF);
    tick();
    issue("lw_both", 1'b1, ld(3'b010, 5'd15), PC,
      32'h1000_0008, 32'h0, 1'b1, 32'hCAFE_F00D);
    tick();

    issue("imem_nb", 1'b1, st(3'b010), PC,
      32'h2000_0010, 32'h1, 1'b0, 32'h0);
    chk("imem_nb_we", {28'h0, bus.imem_we}, 32'h0);
    chk("imem_nb_dwe", {28'h0, bus.dmem_we}, 32'h0);
    tick();
    issue("imem_b", 1'b1, st(3'b010), PCB,
      32'h2000_0010, 32'h1, 1'b0, 32'h0);
    chk("imem_b_we", {28'h0, bus.imem_we}, 32'hF);
    tick();

    issue("sh_mis", 1'b1, st(3'b001), PC,
      32'h1000_0001, 32'hFFFF, 1'b0, 32'h0);
    chk("sh_mis_flag", {31'h0, misaligned}, 32'h1);
    chk("sh_mis_we", {28'h0, bus.dmem_we}, 32'h0);
    tick();
    issue("lw_mis", 1'b1, ld(3'b010, 5'd16), PC,
      32'h1000_0002, 32'h0, 1'b0, 32'h0);
    chk("lw_mis_flag", {31'h0, misaligned}, 32'h1);
    tick();
    issue("sw_inv", 1'b0, st(3'b010), PC,
      32'h1000_0000, 32'h5, 1'b0, 32'h0);
    chk("sw_inv_we", {28'h0, bus.dmem_we}, 32'h0);
    tick();

    bus.uart_tx_data_in_ready = 1'b1;
    issue("tx1", 1'b1, st(3'b010), PC,
      32'h8000_0008, 32'h41, 1'b0, 32'h0);
    chk("tx1_valid",
      {31'h0, bus.uart_tx_data_in_valid}, 32'h1);
    chk("tx1_byte",
      {24'h0, bus.uart_tx_data_in}, 32'h41);
    tick();
    bub();
    chk("tx1_once",
      {31'h0, bus.uart_tx_data_in_valid}, 32'h0);
    tick();
    bus.uart_tx_data_in_ready = 1'b0;
    issue("tx0", 1'b1, st(3'b010), PC,
      32'h8000_0008, 32'h42, 1'b0, 32'h0);
    chk("tx0_valid",
      {31'h0, bus.uart_tx_data_in_valid}, 32'h1);
    tick();
    bub();
    chk("tx0_noretry",
      {31'h0, bus.uart_tx_data_in_valid}, 32'h0);
    tick();

    bus.uart_rx_data_out       = 8'h7F;
    bus.uart_rx_data_out_valid = 1'b1;
    issue("rx", 1'b1, ld(3'b010, 5'd17), PC,
      32'h8000_0004, 32'h0, 1'b1, 32'h0000_007F);
    chk("rx_ready",
      {31'h0, bus.uart_rx_data_out_ready}, 32'h1);
    tick();
    bub();
    chk("rx_once",
      {31'h0, bus.uart_rx_data_out_ready}, 32'h0);
    tick();
    issue("ctrl", 1'b1, ld(3'b010, 5'd18), PC,
      32'h8000_0000, 32'h0, 1'b1, 32'h2);
    tick();

    issue("bios_lw", 1'b1, ld(3'b010, 5'd19), PC,
      32'h4000_0008, 32'h0, 1'b1, 32'hB105_0002);
    tick();
    issue("bios_lb", 1'b1, ld(3'b000, 5'd20), PC,
      32'h4000_000B, 32'h0, 1'b1, 32'hFFFF_FFB1);
    tick();

    issue("jal", 1'b1, {20'h0, 5'd1, 7'h6F}, PC,
      32'h0000_0777, 32'h0, 1'b1, 32'h0000_0104);
    tick();
    issue("jalr", 1'b1,
      {12'h0, 5'd2, 3'b000, 5'd4, 7'h67}, PCB,
      32'h0000_0888, 32'h0, 1'b1, 32'h4000_0104);
    tick();
    issue("x0", 1'b1, addi(5'd0), PC,
      32'h55, 32'h0, 1'b0, 32'h0);
    tick();
    issue("br", 1'b1,
      {7'h0, 5'h1, 5'h2, 3'b000, 5'h3, 7'h63}, PC,
      32'h1, 32'h0, 1'b0, 32'h0);
    tick();
    issue("csr", 1'b1,
      {12'hC00, 5'h0, 3'b010, 5'd2, 7'h73}, PC,
      32'h1, 32'h0, 1'b0, 32'h0);
    tick();
    issue("add", 1'b1,
      {7'h0, 5'h1, 5'h2, 3'b000, 5'd5, 7'h33}, PC,
      32'h0000_DEAD, 32'h0, 1'b1, 32'h0000_DEAD);
    tick();
    issue("inv", 1'b0, addi(5'd3), PC,
      32'h9, 32'h0, 1'b0, 32'h0);
    tick();

    valid_mem = 1'b1;
    inst_mem  = ld(3'b010, 5'd21);
    alu_mem   = 32'h1000_0004;
    @(posedge clk);
    #1;
    chk("midrst_pre", {31'h0, wb_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'h0, wb_we}, 32'h0);
    chk("midrst_inst", inst_wb, NOP);
    @(negedge clk);
    valid_mem = 1'b0;
    inst_mem  = NOP;
    rst_n     = 1'b1;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
